nco_dout_splitter: RTL and testbench

Downstream neighbour of the NCO core on the pin-limited chip. It captures each valid 12-bit NCO sample (`Dout` qualified by `Vld`) into a small synchronous FIFO, then emits it off-chip as three 4-bit nibbles, MSB first, with a frame-start marker. An off-chip `Hold` input stalls emission. FIFO overflow is flagged sticky instead of stalling the NCO, which has no backpressure.

---
 rtl/nco_io_pkg.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/nco_dout_splitter.sv | 92 +++++++++
 tb/tb_nco_dout_splitter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_io_pkg.sv
// Shared constants and splitter state encoding for the NCO pad-side logic.
package nco_io_pkg;

  localparam int SAMP_W = 12;
  localparam int NIB_W  = 4;
  localparam int BEATS  = SAMP_W / NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } split_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: registered pointers plus occupancy count, head entry always on dout.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nco_dout_splitter.sv
// Buffers NCO samples and emits each off-chip as MS-first nibbles with a frame-start flag.
// Handshake: a nibble is offered while NVld=1 and is consumed on a rising edge where Hold=0;
// while Hold=1 every output stays stable. The NCO side has no backpressure: Vld is always taken.
module nco_dout_splitter
  import nco_io_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int SAMP_W = nco_io_pkg::SAMP_W,
  parameter int NIB_W  = nco_io_pkg::NIB_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Vld,
  input  logic [SAMP_W-1:0] Dout,
  input  logic              Hold,
  output logic [NIB_W-1:0]  Nout,
  output logic              NVld,
  output logic              NFirst,
  output logic              Ovf,
  output logic [1:0]        dbg_state
);

  split_state_t      state;
  split_state_t      state_nxt;
  logic [SAMP_W-1:0] sr;
  logic [SAMP_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              beat_taken;

  assign beat_taken = (state != IDLE) && !Hold;
  // Load a new sample from IDLE or straight after the last beat, so frames run back to back.
  assign fifo_pop   = !Hold && !fifo_empty && ((state == IDLE) || (state == B2));

  sync_fifo #(
    .WIDTH (SAMP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (Vld),
    .din   (Dout),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty && !Hold) state_nxt = B0;
      B0:      if (!Hold) state_nxt = B1;
      B1:      if (!Hold) state_nxt = B2;
      B2:      if (!Hold) state_nxt = fifo_empty ? IDLE : B0;
      default: state_nxt = IDLE;
    endcase
  end

  // The current beat always sits in the top nibble; each consumed beat shifts the next one up.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (fifo_pop) begin
      sr <= fifo_dout;
    end else if (beat_taken) begin
      sr <= sr << NIB_W;
    end
  end

  // Full is judged before any same-edge pop, so a sample arriving while full is lost.
  always_ff @(posedge clk) begin
    if (rst)                  Ovf <= 1'b0;
    else if (Vld && fifo_full) Ovf <= 1'b1;
  end

  always_comb begin
    Nout   = '0;
    NVld   = (state != IDLE);
    NFirst = (state == B0);
    if (state != IDLE) Nout = sr[SAMP_W-1 -: NIB_W];
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_nco_dout_splitter.sv
// Scenario bench for nco_dout_splitter: per-feature tasks plus a nibble scoreboard.
module tb_nco_dout_splitter;

  logic        clk;
  logic        rst;
  logic        Vld;
  logic [11:0] Dout;
  logic        Hold;
  logic [3:0]  Nout;
  logic        NVld;
  logic        NFirst;
  logic        Ovf;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;
  bit mon_en;

  // {first_flag, nibble} for every beat expected off-chip, in order
  logic [4:0] exp_q[$];

  nco_dout_splitter #(.DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .Vld       (Vld),
    .Dout      (Dout),
    .Hold      (Hold),
    .Nout      (Nout),
    .NVld      (NVld),
    .NFirst    (NFirst),
    .Ovf       (Ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  // drivers
  task automatic push_sample(input logic [11:0] d, input bit keep);
    Vld  = 1'b1;
    Dout = d;
    if (keep) begin
      for (int b = 0; b < 3; b++) exp_q.push_back({(b == 0), d[11-4*b -: 4]});
    end
    cyc();
    Vld  = 1'b0;
    Dout = '0;
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || NVld) && n < max_cycles) begin
      cyc();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0 || NVld) begin
      miscompares++;
      $display("FAIL %s drain timeout: %0d beats still expected, NVld=%b, required 0 beats", name, exp_q.size(), NVld);
    end
  endtask

  // scoreboard: compare each consumed beat against the expected queue
  always @(negedge clk) begin
    if (mon_en && !rst && NVld && !Hold) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_beat: got first=%b nib=%h, required no beat", NFirst, Nout);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({NFirst, Nout} !== e) begin
          miscompares++;
          $display("FAIL sb_beat: got first=%b nib=%h, required first=%b nib=%h", NFirst, Nout, e[4], e[3:0]);
        end
      end
    end
  end

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    vectors++;
    if ({NVld, NFirst, Nout, Ovf, dbg_state} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got NVld=%b NFirst=%b Nout=%h Ovf=%b st=%0d, required all 0", NVld, NFirst, Nout, Ovf, dbg_state);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [3:0] exp_nib[3];
    exp_nib[0] = 4'hA; exp_nib[1] = 4'h5; exp_nib[2] = 4'hC;
    push_sample(12'hA5C, 1'b1);
    vectors++;
    if (NVld !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: got NVld=%b in write cycle, required 0", NVld);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if ({NVld, NFirst, Nout} !== {1'b1, (i == 0), exp_nib[i]}) begin
        miscompares++;
        $display("FAIL single_beat%0d: got NVld=%b NFirst=%b Nout=%h, required 1 %b %h", i, NVld, NFirst, Nout, (i == 0), exp_nib[i]);
      end
    end
    cyc();
    vectors++;
    if ({NVld, Nout, dbg_state} !== 7'b0) begin
      miscompares++;
      $display("FAIL single_idle: got NVld=%b Nout=%h st=%0d, required 0 0 0", NVld, Nout, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    push_sample(12'h123, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) begin
        Vld  = 1'b1;
        Dout = 12'h456;
        for (int b = 0; b < 3; b++) exp_q.push_back({(b == 0), Dout[11-4*b -: 4]});
      end else begin
        Vld  = 1'b0;
        Dout = '0;
      end
      cyc();
      Vld = 1'b0;
      vectors++;
      if ({NVld, NFirst, Nout} !== {1'b1, (i == 1 || i == 4), 4'(i)}) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: got NVld=%b NFirst=%b Nout=%h, required 1 %b %h", i, NVld, NFirst, Nout, (i == 1 || i == 4), 4'(i));
      end
    end
    cyc();
    vectors++;
    if (NVld !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got NVld=%b, required 0", NVld);
    end
  endtask

  task automatic test_hold_stall();
    push_sample(12'hF0E, 1'b1);
    cyc();
    cyc();
    Hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc();
      vectors++;
      if ({NVld, NFirst, Nout} !== {1'b1, 1'b0, 4'h0}) begin
        miscompares++;
        $display("FAIL hold_b1_cycle%0d: got NVld=%b NFirst=%b Nout=%h, required 1 0 0", i, NVld, NFirst, Nout);
      end
    end
    Hold = 1'b0;
    cyc();
    vectors++;
    if ({NVld, Nout} !== {1'b1, 4'hE}) begin
      miscompares++;
      $display("FAIL hold_release: got NVld=%b Nout=%h, required 1 e", NVld, Nout);
    end
    wait_drain(10, "hold_stall");
  endtask

  task automatic test_hold_toggle();
    logic [5:0] snap;
    bit         h;
    push_sample(12'h7B2, 1'b1);
    push_sample(12'h9C4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      Hold = i[0];
      h    = Hold;
      snap = {NVld, NFirst, Nout};
      cyc();
      if (h && snap[5]) begin
        vectors++;
        if ({NVld, NFirst, Nout} !== snap) begin
          miscompares++;
          $display("FAIL toggle_stable: got %b, required %b held", {NVld, NFirst, Nout}, snap);
        end
      end
    end
    Hold = 1'b0;
    wait_drain(20, "hold_toggle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      push_sample(12'($urandom_range(0, 4095)), 1'b1);
      repeat ($urandom_range(2, 5)) cyc();
    end
    wait_drain(30, "random");
    vectors++;
    if (Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL random_ovf: got Ovf=%b, required 0", Ovf);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    Hold = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push_sample(12'(i), (i <= 8));
      if (i == 8 || i == 9) begin
        vectors++;
        if (Ovf !== (i == 9)) begin
          miscompares++;
          $display("FAIL ovf_after_%0d: got Ovf=%b, required %b", i, Ovf, (i == 9));
        end
      end
    end
    Hold = 1'b0;
    wait_drain(60, "overflow");
    vectors++;
    if (Ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_sticky: got Ovf=%b, required 1", Ovf);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    Hold = 1'b1;
    for (int i = 1; i <= 8; i++) push_sample(12'h100 + 12'(i), 1'b1);
    Hold = 1'b0;
    cyc();
    push_sample(12'h109, 1'b1);
    cyc();
    vectors++;
    if (dbg_state !== 2'd3 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_setup: got st=%0d Ovf=%b, required 3 0", dbg_state, Ovf);
    end
    push_sample(12'h10A, 1'b0);
    vectors++;
    if (Ovf !== 1'b1 || dbg_state !== 2'd1) begin
      miscompares++;
      $display("FAIL fullpop_drop: got Ovf=%b st=%0d, required 1 1", Ovf, dbg_state);
    end
    wait_drain(60, "full_pop");
  endtask

  task automatic test_reset_midframe();
    int bad;
    Hold = 1'b1;
    for (int i = 1; i <= 4; i++) push_sample(12'h200 + 12'(i), 1'b1);
    Hold = 1'b0;
    cyc();
    cyc();
    vectors++;
    if (dbg_state !== 2'd2 || Ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_setup: got st=%0d Ovf=%b, required 2 1", dbg_state, Ovf);
    end
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    vectors++;
    if (NVld !== 1'b0 || Ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_next: got NVld=%b Ovf=%b, required 0 0", NVld, Ovf);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (NVld !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midrst_quiet: got %0d cycles with NVld=1, required 0", bad);
    end
    push_sample(12'h3AB, 1'b1);
    wait_drain(10, "midrst_resume");
  endtask

  initial begin
    rst    = 1'b1;
    Vld    = 1'b0;
    Dout   = '0;
    Hold   = 1'b0;
    mon_en = 1'b0;
    vectors     = 0;
    miscompares = 0;

    test_reset();
    test_single();
    test_back_to_back();
    test_hold_stall();
    test_hold_toggle();
    test_random();
    test_overflow();
    test_full_pop();
    test_reset_midframe();

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: got %0d beats outstanding, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
